bit_destuffing: RTL and testbench
=================================

Name: bit_destuffing

Overview:
Receive-side counterpart of the CAN transmit bit stuffer. Sits between the bit-timing/sampling logic and the receive frame decoder. On every sampled bit it removes the complementary stuff bit that follows STUFF_LEN consecutive identical bits, forwards only payload bits, and flags a stuff error when the expected complementary bit is missing. Checking applies from SOF through the end of the CRC sequence (destuff_en window); outside that window bits pass through unchanged.

Parameters:
STUFF_LEN, 5, number of consecutive identical bits after which one complementary stuff bit is expected (legal range 2..7)
CNT_W, 3, width of the run-length counter; must satisfy 2^CNT_W > STUFF_LEN

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sample_point  input  1  one-clk strobe; rx_bit is valid and is consumed on this cycle
rx_bit  input  1  sampled bus bit (0 = dominant, 1 = recessive)
frame_start  input  1  asserted together with the sample_point of the SOF bit; restarts run tracking and clears error state
destuff_en  input  1  high while the stuffed region (SOF..last CRC bit) is being received
data_out  output  1  destuffed bit
data_out_valid  output  1  one-clk pulse, data_out is a payload bit
stuff_dropped  output  1  one-clk pulse, a correct stuff bit was removed
stuff_error  output  1  one-clk pulse, sixth identical bit detected
err_hold  output  1  level; high from a stuff error until the next frame_start or reset

Behaviour:
- Reset (async): data_out=1, data_out_valid=0, stuff_dropped=0, stuff_error=0, err_hold=0, cnt=0, last_bit=1, state=IDLE.
- All outputs registered; every response appears exactly 1 clk after the sample_point cycle. Pulse outputs are 0 on every cycle that is not the cycle after a sample_point.
- No action on cycles without sample_point; internal state holds.
- States: IDLE, COUNT, EXPECT_STUFF, ERROR.
- frame_start (only meaningful with sample_point) overrides every state: bit forwarded (valid=1), last_bit=rx_bit, cnt=1, err_hold cleared, state=COUNT if destuff_en else IDLE.
- IDLE: each sample forwarded (valid=1), no checking; last_bit=rx_bit, cnt=1. Moves to COUNT when a sample arrives with destuff_en=1 (that bit counts as cnt=1).
- COUNT, destuff_en=1: forward bit (valid=1). If rx_bit==last_bit, cnt=cnt+1, else cnt=1, last_bit=rx_bit. When the updated cnt equals STUFF_LEN, go to EXPECT_STUFF.
- COUNT, destuff_en=0: forward bit, go to IDLE, cnt=1.
- EXPECT_STUFF (evaluated regardless of destuff_en, so a stuff bit after the last CRC bit is still removed):
  - rx_bit!=last_bit: no valid, stuff_dropped=1, last_bit=rx_bit, cnt=1 (stuff bit starts the next run), state=COUNT if destuff_en else IDLE.
  - rx_bit==last_bit: no valid, stuff_error=1, err_hold=1, state=ERROR.
- ERROR: samples ignored (no valid, no pulses); exit only via frame_start or rst.
- Counter never exceeds STUFF_LEN; no wrap-around possible.
- rst asserted mid-frame: immediate return to reset values; the partially received frame is discarded by the consumer.

Test Plan:
- Reset then frame_start+SOF 0, destuff_en=1, then bits 0,0,0,0,1 -> after 5th identical 0 (SOF+4) a 1 is dropped: five valid pulses of 0, one stuff_dropped pulse, no valid for the stuff bit.
- Stream 1,1,1,1,1,0,0,0,0,0 with stuff bits inserted (1x5,0,0x4... per stuffing) -> output equals original unstuffed 13-bit vector, stuff_dropped count = 2, stuff_error never set.
- Six identical 0s inside destuff_en window -> five valids, then stuff_error pulse 1 clk after 6th sample, err_hold=1; further samples produce nothing until frame_start, which clears err_hold.
- Last CRC bit completes run of five 1s, destuff_en falls on the next sample carrying 0 -> bit dropped, stuff_dropped=1, state IDLE; following 1,1,1,1,1,1,1 (delimiter/EOF) all forwarded with no error.
- destuff_en=0 with seven consecutive 1s -> seven valid pulses, no stuff_dropped, no stuff_error.
- rst asserted while in EXPECT_STUFF -> all outputs at reset values immediately; next sample without frame_start handled in IDLE (forwarded, no checking).

Source files
------------

// File: rtl/bit_destuffing.sv
// bit_destuffing: CAN receive-side bit destuffer with stuff-error detection.
// Ports: clk/rst (async, active-high); sample_point/rx_bit carry one sampled bit;
// frame_start marks SOF; destuff_en marks the stuffed region (SOF..CRC);
// data_out/data_out_valid carry payload bits; stuff_dropped/stuff_error are
// one-clk pulses; err_hold stays high from a stuff error until the next frame_start.
// All outputs are registered and respond exactly one clk after sample_point.
module bit_destuffing #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_point,
  input  logic rx_bit,
  input  logic frame_start,
  input  logic destuff_en,
  output logic data_out,
  output logic data_out_valid,
  output logic stuff_dropped,
  output logic stuff_error,
  output logic err_hold
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPECT_STUFF, ERROR} state_t;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic [CNT_W-1:0] cnt_next;

  // Run length including the current bit. In COUNT the counter stays below
  // LEN_C, so the increment can never pass STUFF_LEN or wrap.
  always_comb begin
    cnt_next = ONE_C;
    if (rx_bit == last_bit) cnt_next = cnt + ONE_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      last_bit       <= 1'b1;
      data_out       <= 1'b1;
      data_out_valid <= 1'b0;
      stuff_dropped  <= 1'b0;
      stuff_error    <= 1'b0;
      err_hold       <= 1'b0;
    end else begin
      // Pulses are only ever high on the cycle after a sample_point.
      data_out_valid <= 1'b0;
      stuff_dropped  <= 1'b0;
      stuff_error    <= 1'b0;
      if (sample_point) begin
        if (frame_start) begin
          // SOF restarts tracking from any state, including ERROR.
          data_out       <= rx_bit;
          data_out_valid <= 1'b1;
          last_bit       <= rx_bit;
          cnt            <= ONE_C;
          err_hold       <= 1'b0;
          state          <= destuff_en ? COUNT : IDLE;
        end else begin
          case (state)
            IDLE: begin
              data_out       <= rx_bit;
              data_out_valid <= 1'b1;
              last_bit       <= rx_bit;
              cnt            <= ONE_C;
              if (destuff_en) state <= COUNT;
            end
            COUNT: begin
              data_out       <= rx_bit;
              data_out_valid <= 1'b1;
              last_bit       <= rx_bit;
              if (destuff_en) begin
                cnt <= cnt_next;
                if (cnt_next == LEN_C) state <= EXPECT_STUFF;
              end else begin
                cnt   <= ONE_C;
                state <= IDLE;
              end
            end
            EXPECT_STUFF: begin
              // Evaluated regardless of destuff_en: a stuff bit following the
              // last CRC bit must still be removed.
              if (rx_bit != last_bit) begin
                stuff_dropped <= 1'b1;
                last_bit      <= rx_bit;
                cnt           <= ONE_C;
                state         <= destuff_en ? COUNT : IDLE;
              end else begin
                stuff_error <= 1'b1;
                err_hold    <= 1'b1;
                state       <= ERROR;
              end
            end
            default: begin
              // ERROR: ignore samples until frame_start or rst.
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_destuffing.sv
// Directed testbench for bit_destuffing: each sample step checks the registered
// response one clk later, then checks that pulses drop on the following idle cycle.
// Covers reset, stuff drop, multi-stuff stream, stuff error, end-of-CRC stuff, rst mid-run.
module tb_bit_destuffing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_point = 1'b0;
  logic rx_bit = 1'b1;
  logic frame_start = 1'b0;
  logic destuff_en = 1'b0;
  logic data_out, data_out_valid, stuff_dropped, stuff_error, err_hold;

  int checks = 0;
  int errors = 0;

  bit_destuffing #(.STUFF_LEN(5), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
    .frame_start(frame_start), .destuff_en(destuff_en), .data_out(data_out),
    .data_out_valid(data_out_valid), .stuff_dropped(stuff_dropped),
    .stuff_error(stuff_error), .err_hold(err_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample; expected {valid, dropped, error, hold} and data (checked when valid).
  task automatic step(input string tag, input logic rx, input logic fs, input logic en,
                      input logic ev, input logic ed, input logic edrop,
                      input logic eerr, input logic ehold);
    @(negedge clk);
    sample_point = 1'b1; rx_bit = rx; frame_start = fs; destuff_en = en;
    @(posedge clk);
    #1;
    sample_point = 1'b0; frame_start = 1'b0;
    check({tag, " flags"}, {4'b0, data_out_valid, stuff_dropped, stuff_error, err_hold},
          {4'b0, ev, edrop, eerr, ehold});
    if (ev) check({tag, " data"}, {7'b0, data_out}, {7'b0, ed});
    @(posedge clk);
    #1;
    check({tag, " gap"}, {4'b0, data_out_valid, stuff_dropped, stuff_error, err_hold},
          {4'b0, 3'b000, ehold});
  endtask

  // Original 13 bits 0,1,1,1,1,1,0,0,0,0,1,0,1 stuffed into 15 bits.
  logic [14:0] stuffed  = 15'b0_11111_0_0000_1_1_0_1;
  logic [14:0] is_stuff = 15'b0_00000_1_0000_1_0_0_0;

  initial begin
    // Reset state.
    #12;
    check("reset", {3'b0, data_out, data_out_valid, stuff_dropped, stuff_error, err_hold},
          8'b0001_0000);
    @(negedge clk);
    rst = 1'b0;

    // SOF 0 then four 0s: fifth identical 0 expects a stuff 1, which is dropped.
    step("t1 sof",   1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t1 run", 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0);
    step("t1 stuff", 1'b1, 1'b0, 1'b1, 0, 0, 1, 0, 0);
    step("t1 next",  1'b1, 1'b0, 1'b1, 1, 1, 0, 0, 0);

    // Stuffed stream with two stuff bits.
    for (int i = 14; i >= 0; i--) begin
      step("t2 bit", stuffed[i], (i == 14), 1'b1, !is_stuff[i], stuffed[i],
           is_stuff[i], 0, 0);
    end

    // Six identical 0s: error on the sixth, then ignored until frame_start.
    step("t3 sof",  1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t3 run", 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0);
    step("t3 sixth", 1'b0, 1'b0, 1'b1, 0, 0, 0, 1, 1);
    step("t3 ign1",  1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1);
    step("t3 ign0",  1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1);

    // New frame clears err_hold; run of five 1s ends the CRC, stuff 0 arrives with en=0.
    step("t4 sof",   1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t4 crc", 1'b1, 1'b0, 1'b1, 1, 1, 0, 0, 0);
    step("t4 stuff", 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step("t4 eof", 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);

    // Outside the window: seven 0s forwarded without checking.
    for (int i = 0; i < 7; i++) step("t5 nochk", 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0);

    // rst while in EXPECT_STUFF: outputs return to reset values without a clock edge.
    step("t6 sof", 1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t6 run", 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst", {3'b0, data_out, data_out_valid, stuff_dropped, stuff_error, err_hold},
          8'b0001_0000);
    @(negedge clk);
    rst = 1'b0;
    // Would be a stuff error in EXPECT_STUFF; in IDLE it is simply forwarded.
    step("t6 idle", 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
